ps2_scan_tracker: RTL

Converts the raw byte stream from the PS/2 receiver into the held-key and modifier state consumed by the keymapper. Decodes set-2 prefixes (E0 extended, F0 break, E1 pause), tracks shift/control/alt/caps-lock, and presents the most recently pressed non-modifier key as a registered scan code. Sits between the PS/2 serial receiver and the combinational keymapper.

---
 rtl/ps2_scan_tracker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_tracker.sv
// PS/2 set-2 byte stream decoder: follows E0/F0/E1 prefixes, tracks modifier
// and caps-lock state, and holds the most recently pressed non-modifier key.
module ps2_scan_tracker #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_code,
    output logic       special_make,
    output logic       key_pressed,
    output logic       code_strobe,
    output logic       shift_key,
    output logic       control_key,
    output logic       alt_key,
    output logic       caps_lock
);

    // state   | meaning
    // IDLE    | waiting for a make code or a prefix
    // EXT     | E0 seen, next byte is an extended make (or F0)
    // BRK     | F0 seen, next byte is a plain break
    // EXT_BRK | E0 F0 seen, next byte is an extended break
    // PAUSE   | E1 seen, swallowing the rest of the pause sequence

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t        state, state_nx;
    logic [2:0]    skip_cnt, skip_nx;
    logic [TW-1:0] tmo_cnt, tmo_nx;

    logic ev_valid, ev_brk, ev_ext, key_match;
    logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r, caps_held;
    logic shift_l_nx, shift_r_nx, ctrl_l_nx, ctrl_r_nx, alt_l_nx, alt_r_nx, caps_held_nx;
    logic caps_nx, special_nx, pressed_nx, strobe_nx;
    logic [7:0] scan_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            skip_cnt     <= '0;
            tmo_cnt      <= '0;
            shift_l      <= 1'b0;
            shift_r      <= 1'b0;
            ctrl_l       <= 1'b0;
            ctrl_r       <= 1'b0;
            alt_l        <= 1'b0;
            alt_r        <= 1'b0;
            caps_held    <= 1'b0;
            caps_lock    <= 1'b0;
            scan_code    <= 8'h00;
            special_make <= 1'b0;
            key_pressed  <= 1'b0;
            code_strobe  <= 1'b0;
        end else begin
            state        <= state_nx;
            skip_cnt     <= skip_nx;
            tmo_cnt      <= tmo_nx;
            shift_l      <= shift_l_nx;
            shift_r      <= shift_r_nx;
            ctrl_l       <= ctrl_l_nx;
            ctrl_r       <= ctrl_r_nx;
            alt_l        <= alt_l_nx;
            alt_r        <= alt_r_nx;
            caps_held    <= caps_held_nx;
            caps_lock    <= caps_nx;
            scan_code    <= scan_nx;
            special_make <= special_nx;
            key_pressed  <= pressed_nx;
            code_strobe  <= strobe_nx;
        end
    end

    // Prefix tracking: turns raw bytes into make/break events with an ext flag.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        ev_valid = 1'b0;
        ev_brk   = 1'b0;
        ev_ext   = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        8'hE0: state_nx = EXT;
                        8'hF0: state_nx = BRK;
                        8'hE1: begin
                            state_nx = PAUSE;
                            skip_nx  = 3'd7;
                        end
                        8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF: ;
                        default: ev_valid = 1'b1;
                    endcase
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_nx = EXT_BRK;
                    end else begin
                        state_nx = IDLE;
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nx = IDLE;
                    if (rx_data != 8'hE0 && rx_data != 8'hF0 && rx_data != 8'hE1) begin
                        ev_valid = 1'b1;
                        ev_brk   = 1'b1;
                        ev_ext   = (state == EXT_BRK);
                    end
                end
                PAUSE: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        state_nx = IDLE;
                        skip_nx  = 3'd0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            state_nx = IDLE;
        end

        if (rx_valid || state_nx == IDLE) begin
            tmo_nx = '0;
        end else if (tmo_cnt == TMO_LAST) begin
            tmo_nx = tmo_cnt;
        end else begin
            tmo_nx = tmo_cnt + TW'(1);
        end
    end

    assign key_match = key_pressed && ({ev_ext, rx_data} == {special_make, scan_code});

    // Event application: modifiers update their own flops, everything else
    // drives the held-key register and its strobe.
    always_comb begin
        shift_l_nx   = shift_l;
        shift_r_nx   = shift_r;
        ctrl_l_nx    = ctrl_l;
        ctrl_r_nx    = ctrl_r;
        alt_l_nx     = alt_l;
        alt_r_nx     = alt_r;
        caps_held_nx = caps_held;
        caps_nx      = caps_lock;
        scan_nx      = scan_code;
        special_nx   = special_make;
        pressed_nx   = key_pressed;
        strobe_nx    = 1'b0;
        if (ev_valid) begin
            case (rx_data)
                8'h12: if (!ev_ext) shift_l_nx = !ev_brk;
                8'h59: if (!ev_ext) shift_r_nx = !ev_brk;
                8'h14: begin
                    if (ev_ext) ctrl_r_nx = !ev_brk;
                    else        ctrl_l_nx = !ev_brk;
                end
                8'h11: begin
                    if (ev_ext) alt_r_nx = !ev_brk;
                    else        alt_l_nx = !ev_brk;
                end
                8'h58: begin
                    if (ev_brk) begin
                        caps_held_nx = 1'b0;
                    end else begin
                        if (!caps_held) caps_nx = !caps_lock;
                        caps_held_nx = 1'b1;
                    end
                end
                default: begin
                    if (!ev_brk && !key_match) begin
                        scan_nx    = rx_data;
                        special_nx = ev_ext;
                        pressed_nx = 1'b1;
                        strobe_nx  = 1'b1;
                    end else if (ev_brk && key_match) begin
                        scan_nx    = 8'h00;
                        special_nx = 1'b0;
                        pressed_nx = 1'b0;
                        strobe_nx  = 1'b1;
                    end
                end
            endcase
        end
    end

    assign shift_key   = shift_l | shift_r;
    assign control_key = ctrl_l | ctrl_r;
    assign alt_key     = alt_l | alt_r;

endmodule
